// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, mux selects, states, control word.
// Constants only, no latency; no flow control.
// The ALU decoder imports the same aluOp encodings so producer and consumer agree.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam int STATE_W = 4;
    localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
    localparam logic [STATE_W-1:0] S_EXECUTE  = 4'd6;
    localparam logic [STATE_W-1:0] S_ALUWB    = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH   = 4'd8;
    localparam logic [STATE_W-1:0] S_ADDIEX   = 4'd9;
    localparam logic [STATE_W-1:0] S_ADDIWB   = 4'd10;
    localparam logic [STATE_W-1:0] S_JUMP     = 4'd11;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // Last state of every instruction; leaving one of these retires the instruction.
    function automatic logic is_retire_state(input logic [STATE_W-1:0] s);
        return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) ||
               (s == S_ADDIWB) || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Maps the control FSM state to the datapath control word.
// Purely combinational, zero latency; no flow control.
// Unused encodings yield an all-zero word.
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    output ctrl_t              ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS32 datapath; counts retired instructions.
// 2 to 5 cycles per instruction (FETCH to FETCH); outputs are Moore except pcEn.
// No backpressure: the FSM free-runs once reset is released.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             pcEn,
    output logic             iord,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regDst,
    output logic             memToReg,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       pcSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    ctrl_t              ctrl;
    ctrl_t              ctrl_g;

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (is_retire_state(state_q)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    ctrl_out_decode u_out_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Reset gates the control word combinationally so an in-flight write dies the moment rst_n drops.
    always_comb begin
        ctrl_g = ctrl;
        if (!rst_n) begin
            ctrl_g = '0;
        end
    end

    assign pcEn     = ctrl_g.pc_write | (ctrl_g.branch & zero);
    assign iord     = ctrl_g.iord;
    assign memWrite = ctrl_g.mem_write;
    assign irWrite  = ctrl_g.ir_write;
    assign regDst   = ctrl_g.reg_dst;
    assign memToReg = ctrl_g.mem_to_reg;
    assign regWrite = ctrl_g.reg_write;
    assign aluSrcA  = ctrl_g.alu_src_a;
    assign aluSrcB  = ctrl_g.alu_src_b;
    assign aluOp    = ctrl_g.alu_op;
    assign pcSrc    = ctrl_g.pc_src;
    assign illegal  = illegal_q & rst_n;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes the expected per-cycle control word,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    // Bit order: pcEn iord memWrite irWrite regDst memToReg regWrite aluSrcA aluSrcB aluOp pcSrc illegal
    localparam logic [14:0] E_RST    = 15'b0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [14:0] E_FETCH  = 15'b1_0_0_1_0_0_0_0_01_00_00_0;
    localparam logic [14:0] E_FETCHI = 15'b1_0_0_1_0_0_0_0_01_00_00_1;
    localparam logic [14:0] E_DECODE = 15'b0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [14:0] E_ADR    = 15'b0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [14:0] E_MRD    = 15'b0_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [14:0] E_MWB    = 15'b0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [14:0] E_MWR    = 15'b0_1_1_0_0_0_0_0_00_00_00_0;
    localparam logic [14:0] E_EXE    = 15'b0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [14:0] E_AWB    = 15'b0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [14:0] E_BRT    = 15'b1_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [14:0] E_BRN    = 15'b0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [14:0] E_IWB    = 15'b0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [14:0] E_JMP    = 15'b1_0_0_0_0_0_0_0_00_00_10_0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [5:0]       opcode = 6'd35;
    logic             zero = 1'b0;
    logic             pcEn, iord, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
    logic [1:0]       aluSrcB, aluOp, pcSrc;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .zero     (zero),
        .pcEn     (pcEn),
        .iord     (iord),
        .memWrite (memWrite),
        .irWrite  (irWrite),
        .regDst   (regDst),
        .memToReg (memToReg),
        .regWrite (regWrite),
        .aluSrcA  (aluSrcA),
        .aluSrcB  (aluSrcB),
        .aluOp    (aluOp),
        .pcSrc    (pcSrc),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    wire [14:0] obs = {pcEn, iord, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA,
                       aluSrcB, aluOp, pcSrc, illegal};

    typedef struct {
        logic [14:0]      o;
        logic [CNT_W-1:0] r;
        int               id;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_x;
    int               checks = 0;
    int               failures = 0;
    int               vec_id = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            chk($sformatf("ctrl#%0d", mon_x.id), 32'(obs), 32'(mon_x.o));
            chk($sformatf("retired#%0d", mon_x.id), 32'(retired), 32'(mon_x.r));
        end
    end

    // One clock cycle: drive inputs, queue that cycle's expected outputs, advance.
    task automatic cyc(input logic [5:0] op, input logic z, input logic [14:0] e, input bit ret);
        exp_t x;
        opcode = op;
        zero   = z;
        x.o    = e;
        x.r    = exp_ret;
        x.id   = vec_id;
        vec_id++;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (ret) exp_ret = exp_ret + 1'b1;
    endtask

    // Opcodes driven in states that must ignore them are deliberately scrambled.
    task automatic do_lw(input logic [14:0] fe);
        cyc(6'd35, 1'b0, fe, 1'b0);
        cyc(6'd35, 1'b0, E_DECODE, 1'b0);
        cyc(6'd35, 1'b0, E_ADR, 1'b0);
        cyc(6'd63, 1'b1, E_MRD, 1'b0);
        cyc(6'd4,  1'b0, E_MWB, 1'b1);
    endtask

    task automatic do_sw(input logic [14:0] fe);
        cyc(6'd43, 1'b0, fe, 1'b0);
        cyc(6'd43, 1'b0, E_DECODE, 1'b0);
        cyc(6'd43, 1'b0, E_ADR, 1'b0);
        cyc(6'd0,  1'b0, E_MWR, 1'b1);
    endtask

    task automatic do_r(input logic [14:0] fe);
        cyc(6'd0,  1'b0, fe, 1'b0);
        cyc(6'd0,  1'b1, E_DECODE, 1'b0);
        cyc(6'd35, 1'b0, E_EXE, 1'b0);
        cyc(6'd0,  1'b1, E_AWB, 1'b1);
    endtask

    task automatic do_beq(input logic [14:0] fe, input logic z);
        cyc(6'd4, 1'b0, fe, 1'b0);
        cyc(6'd4, 1'b0, E_DECODE, 1'b0);
        cyc(6'd4, z, z ? E_BRT : E_BRN, 1'b1);
    endtask

    task automatic do_addi(input logic [14:0] fe);
        cyc(6'd8,  1'b0, fe, 1'b0);
        cyc(6'd8,  1'b0, E_DECODE, 1'b0);
        cyc(6'd35, 1'b0, E_ADR, 1'b0);
        cyc(6'd8,  1'b0, E_IWB, 1'b1);
    endtask

    task automatic do_j(input logic [14:0] fe);
        cyc(6'd2, 1'b0, fe, 1'b0);
        cyc(6'd2, 1'b0, E_DECODE, 1'b0);
        cyc(6'd2, 1'b0, E_JMP, 1'b1);
    endtask

    task automatic do_ill(input logic [14:0] fe, input logic [5:0] op);
        cyc(op, 1'b0, fe, 1'b0);
        cyc(op, 1'b0, E_DECODE, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cyc(6'd35, 1'b0, E_RST, 1'b0);

        rst_n = 1'b1;
        do_lw(E_FETCH);
        do_sw(E_FETCH);
        do_r(E_FETCH);
        do_beq(E_FETCH, 1'b1);
        do_beq(E_FETCH, 1'b0);
        do_addi(E_FETCH);
        do_j(E_FETCH);
        do_ill(E_FETCH, 6'd63);
        do_lw(E_FETCHI);
        do_ill(E_FETCH, 6'd5);
        do_j(E_FETCHI);

        // R-type aborted by reset dropping in the middle of ALUWB.
        cyc(6'd0, 1'b0, E_FETCH, 1'b0);
        cyc(6'd0, 1'b0, E_DECODE, 1'b0);
        cyc(6'd0, 1'b0, E_EXE, 1'b0);
        begin
            exp_t x;
            x.o  = E_AWB;
            x.r  = exp_ret;
            x.id = vec_id;
            vec_id++;
            sb.push_back(x);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_regWrite", 32'(regWrite), 32'd0);
        chk("abort_retired", 32'(retired), 32'd0);
        chk("abort_outputs", 32'(obs), 32'(E_RST));
        exp_ret = '0;
        @(posedge clk);
        #1;
        cyc(6'd0, 1'b0, E_RST, 1'b0);
        rst_n = 1'b1;

        guard = 0;
        while (exp_ret != {CNT_W{1'b1}} && guard < 20) begin
            do_j(E_FETCH);
            guard++;
        end
        do_j(E_FETCH);
        cyc(6'd2, 1'b0, E_FETCH, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS32 datapath. It is the producer side of the aluOp interface: it sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables. It emits aluOp[1:0] for the existing ALU decoder, which turns aluOp plus funct into aluControl. It sits between the instruction register's opcode field and the datapath muxes and write enables.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
opcode  in  6  instr[31:26] from the instruction register; valid from DECODE onward.
zero  in  1  ALU zero flag; sampled combinationally in BRANCH.
pcEn  out  1  PC register enable; equals pcWrite | (branch & zero).
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
memWrite  out  1  data memory write enable.
irWrite  out  1  instruction register load.
regDst  out  1  write register select: 0 = rt, 1 = rd.
memToReg  out  1  register write-data select: 0 = ALUOut, 1 = MDR.
regWrite  out  1  register file write enable.
aluSrcA  out  1  0 = PC, 1 = register A.
aluSrcB  out  2  00 = B, 01 = constant 4, 10 = signext imm, 11 = signext imm << 2.
aluOp  out  2  00 = add, 01 = sub, 10 = use funct.
pcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Outputs are Moore, decoded from state only. Exception: pcEn also uses zero.
- Reset: on asynchronous assertion of rst_n, state = FETCH, retired = 0, illegal = 0.
- While rst_n = 0, every output is forced to 0, including pcEn, irWrite and aluOp. No fetch occurs during reset.
- States and the non-zero outputs for each (all other outputs are 0):
  - FETCH: irWrite = 1, pcWrite = 1, aluSrcB = 01. Always goes to DECODE.
  - DECODE: aluSrcB = 11 (branch target precompute). Next state by opcode:
    - 35 (lw) or 43 (sw) -> MEMADR
    - 0 (R-type) -> EXECUTE
    - 4 (beq) -> BRANCH
    - 8 (addi) -> ADDIEX
    - 2 (j) -> JUMP
    - any other value -> FETCH, with illegal = 1 for the following cycle.
  - MEMADR: aluSrcA = 1, aluSrcB = 10. Goes to MEMREAD if opcode = 35, else MEMWRITE.
  - MEMREAD: iord = 1 -> MEMWB.
  - MEMWB: memToReg = 1, regWrite = 1 -> FETCH.
  - MEMWRITE: iord = 1, memWrite = 1 -> FETCH.
  - EXECUTE: aluSrcA = 1, aluOp = 10 -> ALUWB.
  - ALUWB: regDst = 1, regWrite = 1 -> FETCH.
  - BRANCH: aluSrcA = 1, aluOp = 01, pcSrc = 01, branch = 1 -> FETCH.
  - ADDIEX: aluSrcA = 1, aluSrcB = 10 -> ADDIWB.
  - ADDIWB: regWrite = 1 -> FETCH.
  - JUMP: pcSrc = 10, pcWrite = 1 -> FETCH.
- Latency in cycles, FETCH to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- retired increments by 1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH or JUMP. An illegal opcode does not increment it.
- retired wraps modulo 2^CNT_W with no saturation.
- illegal is registered: it is high for exactly the cycle in which state is FETCH immediately after the illegal DECODE.
- opcode is only consulted in DECODE and MEMADR; changes to it in other states have no effect.
- Reset asserted mid-instruction aborts that instruction at once:
  - no pending regWrite or memWrite is issued;
  - retired is cleared;
  - after release, the first rising edge executes FETCH.
- Unreachable state encodings recover to FETCH on the next edge with all outputs 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the opcode constants (OP_RTYPE = 0, OP_J = 2, OP_BEQ = 4, OP_ADDI = 8, OP_LW = 35, OP_SW = 43);
  - the aluOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - the aluSrcB and pcSrc encodings;
  - the state enumeration.
  The ALU decoder imports the same aluOp constants.
- One natural sub-module, ctrl_out_decode: a purely combinational state-to-control-word mapping. The FSM, the illegal register and the counter stay in the top module.

Test Plan:
- Reset held 3 cycles with opcode = 35 -> all outputs 0, retired = 0. Release -> first edge shows irWrite = 1, pcEn = 1, aluSrcB = 01; next cycle is DECODE.
- opcode = 35, run 5 cycles -> sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regWrite = 1 and memToReg = 1 only in MEMWB; retired = 1 afterwards. With opcode = 43, MEMWRITE asserts memWrite = 1 and iord = 1, and the instruction takes 4 cycles.
- opcode = 0 -> aluOp = 10 in EXECUTE; ALUWB asserts regDst = 1 and regWrite = 1; back to FETCH after 4 cycles.
- opcode = 4 with zero = 1 -> pcEn = 1 and pcSrc = 01 in BRANCH. Repeat with zero = 0 -> pcEn = 0. Both cases take 3 cycles and increment retired.
- opcode = 63 -> DECODE returns to FETCH, illegal = 1 for exactly one cycle, retired unchanged.
- Drop rst_n asynchronously during ALUWB, mid-cycle -> regWrite falls immediately and retired = 0. Separately, preload retired = 2^CNT_W - 1 (force, or use CNT_W = 4) and complete one j -> retired = 0.
